// File: rtl/filter2d_stream.sv
// filter2d_stream: streaming 3x3 convolution with zero-padded borders,
// self-generated end-of-frame flush and double-buffered coefficients.
module filter2d_stream #(
    parameter int DW     = 8,
    parameter int IMG_W  = 256,
    parameter int IMG_H  = 256,
    parameter int COEF_W = 8,
    parameter int SHIFT  = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_strb,
    input  logic [DW-1:0]     i_data,
    output logic              o_rdy,
    output logic              o_strb,
    output logic [DW-1:0]     o_data,
    output logic              o_eof,
    input  logic              h_write,
    input  logic [3:0]        h_idx,
    input  logic [COEF_W-1:0] h_data
);

    localparam int AW = DW + COEF_W + 5;
    localparam int PW = DW + COEF_W + 1;
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H + 2);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [RW-1:0] ROW_END  = RW'(IMG_H + 1);

    localparam logic signed [COEF_W-1:0] UNITY   = COEF_W'(1 << SHIFT);
    localparam logic signed [AW-1:0]     RND     = (AW'(1) << SHIFT) >> 1;
    localparam logic signed [AW-1:0]     PIX_MAX = AW'((1 << DW) - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } state_t;

    state_t        state_q;
    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;
    logic          rdy_q;

    logic signed [COEF_W-1:0] shadow_q [9];
    logic signed [COEF_W-1:0] active_q [9];

    logic          ev;
    logic [DW-1:0] ev_pix;
    logic          last_pix;
    logic          last_flush;

    // Flush cycles are events carrying a zero pixel; input is refused.
    assign ev         = (state_q == FLUSH) || (i_strb && rdy_q);
    assign ev_pix     = (state_q == FLUSH) ? '0 : i_data;
    assign last_pix   = (row_q == ROW_LAST) && (col_q == COL_LAST);
    assign last_flush = (row_q == ROW_END) && (col_q == '0);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            rdy_q   <= 1'b1;
        end else if (ev) begin
            if (col_q == COL_LAST) begin
                col_q <= '0;
                row_q <= row_q + RW'(1);
            end else begin
                col_q <= col_q + CW'(1);
            end
            case (state_q)
                IDLE: state_q <= RUN;
                RUN: begin
                    if (last_pix) begin
                        state_q <= FLUSH;
                        rdy_q   <= 1'b0;
                    end
                end
                FLUSH: begin
                    if (last_flush) begin
                        state_q <= IDLE;
                        rdy_q   <= 1'b1;
                        col_q   <= '0;
                        row_q   <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_rdy = rdy_q;

    // A write landing on the frame-start edge stays in the shadow bank.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int k = 0; k < 9; k++) begin
                shadow_q[k] <= (k == 4) ? UNITY : '0;
                active_q[k] <= (k == 4) ? UNITY : '0;
            end
        end else begin
            if (h_write && (h_idx < 4'd9)) begin
                shadow_q[h_idx] <= h_data;
            end
            if (ev && (state_q == IDLE)) begin
                active_q <= shadow_q;
            end
        end
    end

    logic [DW-1:0] lb_a_q [IMG_W];
    logic [DW-1:0] lb_b_q [IMG_W];
    logic [DW-1:0] win_q  [3][3];
    logic [DW-1:0] up1;
    logic [DW-1:0] up2;

    assign up1 = lb_a_q[col_q];
    assign up2 = lb_b_q[col_q];

    // Window rows hold pixels n-2W, n-W, n; column 2 is the newest.
    always_ff @(posedge clk) begin
        if (ev) begin
            lb_a_q[col_q] <= ev_pix;
            lb_b_q[col_q] <= up1;
            for (int r = 0; r < 3; r++) begin
                win_q[r][0] <= win_q[r][1];
                win_q[r][1] <= win_q[r][2];
            end
            win_q[0][2] <= up2;
            win_q[1][2] <= up1;
            win_q[2][2] <= ev_pix;
        end
    end

    logic          out_vld;
    logic [RW-1:0] orow;
    logic [CW-1:0] ocol;

    always_comb begin
        out_vld = (row_q >= RW'(2)) ||
                  ((row_q == RW'(1)) && (col_q != '0));
        if (col_q == '0) begin
            orow = row_q - RW'(2);
            ocol = COL_LAST;
        end else begin
            orow = row_q - RW'(1);
            ocol = col_q - CW'(1);
        end
    end

    logic s1_vld_q, s1_eof_q;
    logic s1_top_q, s1_bot_q, s1_lft_q, s1_rgt_q;
    logic s2_vld_q, s2_eof_q;
    logic s3_vld_q, s3_eof_q;

    logic signed [AW-1:0] rsum    [3];
    logic signed [AW-1:0] s2_rs_q [3];
    logic signed [AW-1:0] s3_acc_q;
    logic signed [PW-1:0] prod;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1_vld_q <= 1'b0;
            s2_vld_q <= 1'b0;
            s3_vld_q <= 1'b0;
        end else begin
            s1_vld_q <= ev && out_vld;
            s2_vld_q <= s1_vld_q;
            s3_vld_q <= s2_vld_q;
        end
    end

    always_ff @(posedge clk) begin
        s1_eof_q <= (orow == ROW_LAST) && (ocol == COL_LAST);
        s1_top_q <= (orow == '0);
        s1_bot_q <= (orow == ROW_LAST);
        s1_lft_q <= (ocol == '0);
        s1_rgt_q <= (ocol == COL_LAST);
        s2_eof_q <= s1_eof_q;
        s3_eof_q <= s2_eof_q;
        s2_rs_q  <= rsum;
        s3_acc_q <= s2_rs_q[0] + s2_rs_q[1] + s2_rs_q[2];
    end

    // Out-of-frame taps are muxed away, so stale line data never leaks.
    always_comb begin
        prod = '0;
        for (int r = 0; r < 3; r++) begin
            rsum[r] = '0;
            for (int c = 0; c < 3; c++) begin
                prod = active_q[r*3+c] * $signed({1'b0, win_q[r][c]});
                if (!((r == 0 && s1_top_q) || (r == 2 && s1_bot_q) ||
                      (c == 0 && s1_lft_q) || (c == 2 && s1_rgt_q))) begin
                    rsum[r] = rsum[r] + AW'(prod);
                end
            end
        end
    end

    logic signed [AW-1:0] rnd;
    logic signed [AW-1:0] shf;
    logic [DW-1:0]        o_data_d;
    logic                 o_strb_q;
    logic                 o_eof_q;
    logic [DW-1:0]        o_data_q;

    assign rnd = s3_acc_q + RND;
    assign shf = rnd >>> SHIFT;

    always_comb begin
        if (shf < 0) begin
            o_data_d = '0;
        end else if (shf > PIX_MAX) begin
            o_data_d = '1;
        end else begin
            o_data_d = shf[DW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            o_strb_q <= 1'b0;
            o_eof_q  <= 1'b0;
            o_data_q <= '0;
        end else begin
            o_strb_q <= s3_vld_q;
            o_eof_q  <= s3_vld_q && s3_eof_q;
            if (s3_vld_q) begin
                o_data_q <= o_data_d;
            end
        end
    end

    assign o_strb = o_strb_q;
    assign o_eof  = o_eof_q;
    assign o_data = o_data_q;

endmodule

// File: tb/tb_filter2d_stream.sv
// Bench for filter2d_stream: directed and randomized 4x4 frames checked
// against a frame-level zero-padded convolution model.
module tb_filter2d_stream;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int DW = 8;
    localparam int CW = 8;
    localparam int SH = 4;
    localparam int N  = W * H;

    logic          clk     = 1'b0;
    logic          rstn    = 1'b0;
    logic          i_strb  = 1'b0;
    logic [DW-1:0] i_data  = '0;
    logic          h_write = 1'b0;
    logic [3:0]    h_idx   = '0;
    logic [CW-1:0] h_data  = '0;
    logic          o_rdy;
    logic          o_strb;
    logic          o_eof;
    logic [DW-1:0] o_data;

    int errors  = 0;
    int checks  = 0;
    int cyc     = 0;
    int rdy_low = 0;
    int oq_d[$];
    int oq_e[$];
    int oq_c[$];
    int img_m[N];
    int cf_m[9];
    int exp_m[N];

    filter2d_stream #(
        .DW(DW), .IMG_W(W), .IMG_H(H), .COEF_W(CW), .SHIFT(SH)
    ) dut (
        .clk(clk), .rstn(rstn),
        .i_strb(i_strb), .i_data(i_data), .o_rdy(o_rdy),
        .o_strb(o_strb), .o_data(o_data), .o_eof(o_eof),
        .h_write(h_write), .h_idx(h_idx), .h_data(h_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o_strb) begin
            oq_d.push_back(int'(o_data));
            oq_e.push_back(int'(o_eof));
            oq_c.push_back(cyc);
        end
        if (!o_rdy) rdy_low = rdy_low + 1;
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_frame();
        int acc;
        int rr;
        int cc;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                acc = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        rr = r + dr;
                        cc = c + dc;
                        if (rr >= 0 && rr < H && cc >= 0 && cc < W)
                            acc += cf_m[(dr+1)*3 + dc+1] * img_m[rr*W + cc];
                    end
                end
                acc = (acc + (1 << (SH - 1))) >>> SH;
                if (acc < 0) acc = 0;
                if (acc > 255) acc = 255;
                exp_m[r*W + c] = acc;
            end
        end
    endtask

    task automatic set_coefs();
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            h_write = 1'b1;
            h_idx   = 4'(k);
            h_data  = CW'(cf_m[k]);
        end
        @(negedge clk);
        h_idx  = 4'd13;
        h_data = 8'h55;
        @(negedge clk);
        h_write = 1'b0;
    endtask

    task automatic send_pix(input int d, input int gap, input bit wr);
        int n;
        n = 0;
        @(negedge clk);
        while (!o_rdy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("rdy_wait", int'(o_rdy), 1);
        i_strb = 1'b1;
        i_data = DW'(d);
        if (wr) begin
            h_write = 1'b1;
            h_idx   = 4'd0;
            h_data  = 8'd1;
        end
        @(negedge clk);
        i_strb  = 1'b0;
        h_write = 1'b0;
        for (int g = 0; g < gap; g++) begin
            if (wr && g < 8) begin
                h_write = 1'b1;
                h_idx   = 4'(g + 1);
                h_data  = 8'd1;
            end
            @(negedge clk);
            h_write = 1'b0;
        end
    endtask

    task automatic expect_frame(input string tag, input int base);
        int n;
        int od;
        int oe;
        n = 0;
        while (oq_d.size() < base + N && n < 400) begin
            @(negedge clk);
            n++;
        end
        repeat (12) @(negedge clk);
        check({tag, "_count"}, oq_d.size() - base, N);
        for (int i = 0; i < N; i++) begin
            od = (base + i < oq_d.size()) ? oq_d[base+i] : -1;
            oe = (base + i < oq_e.size()) ? oq_e[base+i] : -1;
            check($sformatf("%s_px%0d", tag, i), od, exp_m[i]);
            check($sformatf("%s_eof%0d", tag, i), oe, (i == N-1) ? 1 : 0);
        end
    endtask

    task automatic run_frame(input string tag, input int gap, input bit rnd);
        int base;
        base = oq_d.size();
        model_frame();
        for (int i = 0; i < N; i++)
            send_pix(img_m[i], rnd ? int'($urandom_range(gap)) : gap, 1'b0);
        expect_frame(tag, base);
    endtask

    task automatic cf_fill(input int v, input int centre);
        for (int k = 0; k < 9; k++) cf_m[k] = v;
        cf_m[4] = centre;
    endtask

    initial begin
        int base;
        int rb;
        int k;
        int n;
        int ev5;
        int fst;
        int lst;

        rstn = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_strb", int'(o_strb), 0);
        check("rst_eof", int'(o_eof), 0);
        check("rst_data", int'(o_data), 0);
        check("rst_rdy", int'(o_rdy), 1);
        rstn = 1'b1;

        cf_fill(0, 16);
        for (int i = 0; i < N; i++) img_m[i] = i;
        rb = rdy_low;
        run_frame("t1", 16, 1'b0);
        check("t1_rdy_low", rdy_low - rb, W + 1);

        cf_fill(1, 1);
        set_coefs();
        for (int i = 0; i < N; i++) img_m[i] = 16;
        run_frame("t2", 1, 1'b0);

        cf_fill(0, 127);
        set_coefs();
        for (int i = 0; i < N; i++) img_m[i] = 255;
        run_frame("t3hi", 0, 1'b0);
        cf_fill(0, -16);
        set_coefs();
        run_frame("t3lo", 0, 1'b0);

        cf_fill(0, 16);
        set_coefs();
        for (int i = 0; i < N; i++) img_m[i] = int'($urandom_range(255));
        base = oq_d.size();
        model_frame();
        for (int i = 0; i < N; i++) send_pix(img_m[i], 9, i == 6);
        expect_frame("t4a", base);
        cf_fill(1, 1);
        for (int i = 0; i < N; i++) img_m[i] = int'($urandom_range(255));
        run_frame("t4b", 3, 1'b1);

        for (int i = 0; i < N; i++) img_m[i] = int'($urandom_range(255));
        base = oq_d.size();
        model_frame();
        k = 0;
        n = 0;
        ev5 = -100;
        @(negedge clk);
        while (k < N && n < 200) begin
            i_strb = 1'b1;
            i_data = DW'(img_m[k]);
            if (o_rdy) begin
                if (k == 5) ev5 = cyc + 1;
                k++;
            end
            @(negedge clk);
            n++;
        end
        n = 0;
        while (!o_rdy && n < 50) begin
            i_strb = 1'b1;
            i_data = 8'hAA;
            @(negedge clk);
            n++;
        end
        i_strb = 1'b0;
        check("t5_flush_len", n, W + 1);
        expect_frame("t5", base);
        fst = (oq_c.size() > base) ? oq_c[base] : -1;
        lst = (oq_c.size() >= base + N) ? oq_c[base+N-1] : -1;
        check("t5_first_lat", fst, ev5 + 3);
        check("t5_b2b_span", lst - fst, N - 1);

        cf_fill(0, 16);
        for (int i = 0; i < 8; i++) send_pix(i, (i == 7) ? 0 : 2, 1'b0);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        base = oq_d.size();
        check("t6_rst_strb", int'(o_strb), 0);
        check("t6_rst_rdy", int'(o_rdy), 1);
        check("t6_rst_data", int'(o_data), 0);
        repeat (20) @(negedge clk);
        check("t6_stale", oq_d.size() - base, 0);
        for (int i = 0; i < N; i++) img_m[i] = i;
        run_frame("t6", 2, 1'b0);

        for (int f = 0; f < 3; f++) begin
            for (int j = 0; j < 9; j++) cf_m[j] = int'($urandom_range(40)) - 20;
            set_coefs();
            for (int i = 0; i < N; i++) img_m[i] = int'($urandom_range(255));
            run_frame($sformatf("t7f%0d", f), 3, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
